// File: rtl/cache_fill_arbiter.sv
// Two-channel cache-line fill controller: arbitrates I/D misses, streams the line's read
// addresses to memory, writes returned words, then writes the tag of the selected cache.
module cache_fill_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned WORDS      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_miss,
  input  logic [ADDR_W-1:0] ic_miss_addr,
  input  logic              dc_miss,
  input  logic [ADDR_W-1:0] dc_miss_addr,
  output logic              ic_busy,
  output logic              dc_busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_data,
  output logic              fill_sel,
  output logic              fill_data_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [15:0]       fill_data,
  output logic              fill_tag_we,
  output logic              fill_done
);

  localparam int unsigned Off   = $clog2(WORDS * WORD_BYTES);
  localparam int unsigned WbSh  = $clog2(WORD_BYTES);
  localparam int unsigned CntW  = $clog2(WORDS) + 1;
  localparam logic [CntW-1:0]   CntWords = CntW'(WORDS);
  localparam logic [CntW-1:0]   CntLast  = CntW'(WORDS - 1);
  localparam logic [CntW-1:0]   CntOne   = CntW'(1);
  localparam logic [ADDR_W-1:0] LineMask = ~ADDR_W'((64'd1 << Off) - 64'd1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e            state_q;
  logic              sel_q;
  logic              last_q;
  logic [ADDR_W-1:0] base_q;
  logic [CntW-1:0]   iss_cnt_q;
  logic [CntW-1:0]   ret_cnt_q;

  logic              grant;
  logic              grant_sel;
  logic [ADDR_W-1:0] grant_addr;
  logic              issue;
  logic              accept;

  // When both caches miss, the channel not served last wins.
  always_comb begin
    grant      = ic_miss | dc_miss;
    grant_sel  = (ic_miss & dc_miss) ? ~last_q : dc_miss;
    grant_addr = grant_sel ? dc_miss_addr : ic_miss_addr;
    issue      = (state_q == StFill) && (iss_cnt_q < CntWords);
    accept     = (state_q == StFill) && mem_data_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= 1'b0;
      last_q    <= 1'b0;
      base_q    <= '0;
      iss_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant) begin
            sel_q     <= grant_sel;
            base_q    <= grant_addr & LineMask;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
            state_q   <= StFill;
          end
        end
        StFill: begin
          if (issue) begin
            iss_cnt_q <= iss_cnt_q + CntOne;
          end
          if (accept) begin
            ret_cnt_q <= ret_cnt_q + CntOne;
            if (ret_cnt_q == CntLast) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          last_q  <= sel_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Returned words pass straight through to the data array in their arrival cycle.
  always_comb begin
    mem_rd       = issue;
    mem_addr     = '0;
    fill_sel     = sel_q;
    fill_data_we = accept;
    fill_addr    = '0;
    fill_data    = '0;
    fill_tag_we  = (state_q == StDone);
    fill_done    = (state_q == StDone);
    if (issue) begin
      mem_addr = base_q + (ADDR_W'(iss_cnt_q) << WbSh);
    end
    if (accept) begin
      fill_addr = base_q + (ADDR_W'(ret_cnt_q) << WbSh);
      fill_data = mem_data;
    end else if (state_q == StDone) begin
      fill_addr = base_q;
    end
    ic_busy = ic_miss | ((state_q != StIdle) & ~sel_q);
    dc_busy = dc_miss | ((state_q != StIdle) & sel_q);
  end

endmodule
